// File: rtl/dmem_arbiter.sv
// Data-cache port arbiter between the pipeline memory port (P) and the loader/debug port (D).
// Owns the LL/SC reservation and decides store-conditional success.
//
// Handshake: the grant is combinational in the cycle of the request. D holds
// d_req/d_addr/d_we/d_wdata until d_gnt; P holds its request while p_stall.
// Read data and the stc result are registered and appear one cycle later.
module dmem_arbiter #(
    parameter int ADDR_BITS  = 10,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        p_req,
    input  logic        p_we,
    input  logic        p_ldl,
    input  logic        p_stc,
    input  logic [63:0] p_addr,
    input  logic [63:0] p_wdata,
    output logic        p_stall,
    output logic        p_rvalid,
    output logic        p_stc_ok,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [63:0] d_addr,
    input  logic [63:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic        mem_we,
    input  logic [63:0] mem_rdata
);

    localparam logic [3:0]           STARVE_LIM = 4'(STARVE_MAX);
    localparam logic [ADDR_BITS-1:0] OVL_SPAN   = ADDR_BITS'(8);

    logic                 resv_valid;
    logic [ADDR_BITS-1:0] resv_addr;
    logic [3:0]           starve_cnt;

    logic                 forced;
    logic                 p_gnt;
    logic                 stc_hit;
    logic                 plain_wr;
    logic                 wr_ovl;
    logic [ADDR_BITS-1:0] wr_low;
    logic [ADDR_BITS-1:0] diff_ab;
    logic [ADDR_BITS-1:0] diff_ba;

    // Grants are gated by rst_n so the cache sees no write while reset is held.
    always_comb begin
        forced    = d_req && (starve_cnt == STARVE_LIM);
        d_gnt     = rst_n && d_req && (!p_req || forced);
        p_gnt     = rst_n && p_req && !d_gnt;
        p_stall   = p_req && d_gnt;
        stc_hit   = resv_valid && (p_addr[ADDR_BITS-1:0] == resv_addr);
        mem_addr  = d_gnt ? d_addr : p_addr;
        mem_wdata = d_gnt ? d_wdata : p_wdata;
        mem_we    = 1'b0;
        if (d_gnt) begin
            mem_we = d_we;
        end else if (p_gnt) begin
            mem_we = p_we || (p_stc && stc_hit);
        end
        plain_wr = (d_gnt && d_we) || (p_gnt && p_we);
        wr_low   = d_gnt ? d_addr[ADDR_BITS-1:0] : p_addr[ADDR_BITS-1:0];
        diff_ab  = wr_low - resv_addr;
        diff_ba  = resv_addr - wr_low;
        wr_ovl   = (diff_ab < OVL_SPAN) || (diff_ba < OVL_SPAN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resv_valid <= 1'b0;
            resv_addr  <= '0;
        end else if (p_gnt && p_ldl) begin
            resv_valid <= 1'b1;
            resv_addr  <= p_addr[ADDR_BITS-1:0];
        end else if (p_gnt && p_stc) begin
            resv_valid <= 1'b0;
        end else if (plain_wr && wr_ovl) begin
            resv_valid <= 1'b0;
        end
    end

    // Forced slot fires once the count reaches the limit, so it never exceeds it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (!d_req || d_gnt) begin
            starve_cnt <= '0;
        end else if (starve_cnt < STARVE_LIM) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
            p_stc_ok <= 1'b0;
        end else begin
            p_rvalid <= p_gnt && !p_we && !p_stc;
            d_rvalid <= d_gnt && !d_we;
            if (p_gnt && p_stc) begin
                p_stc_ok <= stc_hit;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a cache stand-in, a behavioural reference model with a
// read-data expected queue, directed scenarios and a randomized run.
module tb_dmem_arbiter;

    localparam int ADDR_BITS  = 10;
    localparam int STARVE_MAX = 4;
    localparam longint unsigned MASK = (64'd1 << ADDR_BITS) - 64'd1;

    logic        clk;
    logic        rst_n;
    logic        p_req, p_we, p_ldl, p_stc;
    logic [63:0] p_addr, p_wdata;
    logic        p_stall, p_rvalid, p_stc_ok;
    logic        d_req, d_we;
    logic [63:0] d_addr, d_wdata;
    logic        d_gnt, d_rvalid;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    dmem_arbiter #(.ADDR_BITS(ADDR_BITS), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .p_req(p_req), .p_we(p_we), .p_ldl(p_ldl), .p_stc(p_stc),
        .p_addr(p_addr), .p_wdata(p_wdata),
        .p_stall(p_stall), .p_rvalid(p_rvalid), .p_stc_ok(p_stc_ok),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- cache stand-in (byte-address slots, registered read) ----------------
    logic [63:0] cache [1024];
    initial for (int i = 0; i < 1024; i++) cache[i] = 64'd0;
    always @(posedge clk) begin
        mem_rdata <= cache[mem_addr[ADDR_BITS-1:0]];
        if (mem_we) cache[mem_addr[ADDR_BITS-1:0]] <= mem_wdata;
    end

    // ---------------- reference model ----------------
    logic [63:0]     shadow [1024];
    logic [63:0]     exp_q [$];
    bit              m_resv_v;
    longint unsigned m_resv_a;
    int              m_lost;
    bit              m_prv, m_drv, m_ok;
    bit              e_d_gnt, e_p_win, e_p_stall, e_hit, e_mem_we;
    logic [63:0]     e_mem_addr, e_mem_wdata;

    initial for (int i = 0; i < 1024; i++) shadow[i] = 64'd0;

    function automatic bit overlaps(longint unsigned a, longint unsigned b);
        longint unsigned x, y;
        x = (a - b) & MASK;
        y = (b - a) & MASK;
        return (x < 8) || (y < 8);
    endfunction

    task automatic model_reset();
        m_resv_v = 0; m_resv_a = 0; m_lost = 0;
        m_prv = 0; m_drv = 0; m_ok = 0;
        exp_q.delete();
    endtask

    task automatic model_eval();
        bit forced;
        forced      = d_req && (m_lost >= STARVE_MAX);
        e_d_gnt     = d_req && (!p_req || forced);
        e_p_win     = p_req && !e_d_gnt;
        e_p_stall   = p_req && e_d_gnt;
        e_hit       = m_resv_v && ((p_addr & MASK) == m_resv_a);
        e_mem_addr  = e_d_gnt ? d_addr : p_addr;
        e_mem_wdata = e_d_gnt ? d_wdata : p_wdata;
        if (e_d_gnt)      e_mem_we = d_we;
        else if (e_p_win) e_mem_we = p_we || (p_stc && e_hit);
        else              e_mem_we = 0;
    endtask

    task automatic model_clock();
        m_prv = e_p_win && !p_we && !p_stc;
        m_drv = e_d_gnt && !d_we;
        if (m_prv || m_drv) exp_q.push_back(shadow[e_mem_addr & MASK]);
        if (e_p_win && p_stc) m_ok = e_hit;
        if (e_p_win && p_ldl) begin
            m_resv_v = 1; m_resv_a = p_addr & MASK;
        end else if (e_p_win && p_stc) begin
            m_resv_v = 0;
        end else if (e_p_win && p_we && overlaps(p_addr, m_resv_a)) begin
            m_resv_v = 0;
        end else if (e_d_gnt && d_we && overlaps(d_addr, m_resv_a)) begin
            m_resv_v = 0;
        end
        if (e_mem_we) shadow[e_mem_addr & MASK] = e_mem_wdata;
        if (d_req && !e_d_gnt) m_lost = (m_lost + 1 > STARVE_MAX) ? STARVE_MAX : m_lost + 1;
        else                   m_lost = 0;
    endtask

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            logic [5:0]  obs_f, exp_f;
            logic [63:0] exp_d;
            model_eval();
            obs_f = {d_gnt, p_stall, mem_we, p_rvalid, d_rvalid, p_stc_ok};
            exp_f = {e_d_gnt, e_p_stall, e_mem_we, m_prv, m_drv, m_ok};
            checks++;
            if (obs_f !== exp_f) begin
                errors++;
                $display("FAIL flags {d_gnt,p_stall,mem_we,p_rv,d_rv,stc_ok} got %b exp %b t=%0t", obs_f, exp_f, $time);
            end
            checks++;
            if ({mem_addr, mem_wdata} !== {e_mem_addr, e_mem_wdata}) begin
                errors++;
                $display("FAIL mem_bus addr/wdata got %h/%h exp %h/%h t=%0t", mem_addr, mem_wdata, e_mem_addr, e_mem_wdata, $time);
            end
            if (m_prv || m_drv) begin
                exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
                checks++;
                if (mem_rdata !== exp_d) begin
                    errors++;
                    $display("FAIL rdata got %h exp %h t=%0t", mem_rdata, exp_d, $time);
                end
            end
        end
    end

    always @(posedge clk) begin
        if (!rst_n)      model_reset();
        else if (chk_en) model_clock();
    end

    // ---------------- driver tasks ----------------
    localparam int K_LD = 0, K_WE = 1, K_LDL = 2, K_STC = 3;

    task automatic set_p(bit req, int kind, logic [63:0] a, logic [63:0] w);
        p_req = req; p_addr = a; p_wdata = w;
        p_we  = req && (kind == K_WE);
        p_ldl = req && (kind == K_LDL);
        p_stc = req && (kind == K_STC);
    endtask

    task automatic set_d(bit req, bit we, logic [63:0] a, logic [63:0] w);
        d_req = req; d_we = req && we; d_addr = a; d_wdata = w;
    endtask

    task automatic idle();
        set_p(0, K_LD, 64'd0, 64'd0);
        set_d(0, 0, 64'd0, 64'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        set_p(1, K_WE, 64'h40, 64'h1);
        set_d(1, 1, 64'h40, 64'h2);
        #3;
        checks++;
        if ({d_gnt, p_stall, mem_we, p_rvalid, d_rvalid, p_stc_ok} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs got %b exp 000000", {d_gnt, p_stall, mem_we, p_rvalid, d_rvalid, p_stc_ok});
        end
        tick();
        idle();
        rst_n = 1'b1;
        chk_en = 1'b1;
        tick();
    endtask

    task automatic test_resv_hit();
        set_p(1, K_LDL, 64'h40, 64'h0);
        tick();
        set_p(1, K_STC, 64'h40, 64'hAA);
        @(negedge clk);
        checks++;
        if (mem_we !== 1'b1) begin errors++; $display("FAIL hit_stc_we got %b exp 1", mem_we); end
        tick();
        set_p(1, K_LD, 64'h40, 64'h0);
        @(negedge clk);
        checks++;
        if (p_stc_ok !== 1'b1) begin errors++; $display("FAIL hit_stc_ok got %b exp 1", p_stc_ok); end
        tick();
        idle();
        @(negedge clk);
        checks++;
        if (p_rvalid !== 1'b1 || mem_rdata !== 64'hAA) begin
            errors++; $display("FAIL hit_readback rv=%b data=%h exp rv=1 data=aa", p_rvalid, mem_rdata);
        end
        tick();
    endtask

    task automatic test_resv_break();
        set_p(1, K_LDL, 64'h40, 64'h0);
        tick();
        set_p(0, K_LD, 64'h0, 64'h0);
        set_d(1, 1, 64'h44, 64'h55);
        tick();
        set_d(0, 0, 64'h0, 64'h0);
        set_p(1, K_STC, 64'h40, 64'hBB);
        @(negedge clk);
        checks++;
        if (mem_we !== 1'b0) begin errors++; $display("FAIL break_stc_we got %b exp 0", mem_we); end
        tick();
        set_p(1, K_LD, 64'h40, 64'h0);
        @(negedge clk);
        checks++;
        if (p_stc_ok !== 1'b0) begin errors++; $display("FAIL break_stc_ok got %b exp 0", p_stc_ok); end
        tick();
        idle();
        @(negedge clk);
        checks++;
        if (mem_rdata !== 64'hAA) begin errors++; $display("FAIL break_mem got %h exp aa", mem_rdata); end
        tick();
    endtask

    task automatic test_nonoverlap();
        set_p(1, K_LDL, 64'h40, 64'h0);
        tick();
        set_p(0, K_LD, 64'h0, 64'h0);
        set_d(1, 1, 64'h48, 64'h66);
        tick();
        set_d(0, 0, 64'h0, 64'h0);
        set_p(1, K_STC, 64'h40, 64'hCC);
        tick();
        idle();
        @(negedge clk);
        checks++;
        if (p_stc_ok !== 1'b1) begin errors++; $display("FAIL nonovl_stc_ok got %b exp 1", p_stc_ok); end
        tick();
    endtask

    task automatic test_starve();
        set_p(1, K_LD, 64'h80, 64'h0);
        set_d(1, 0, 64'h100, 64'h0);
        for (int c = 0; c <= 5; c++) begin
            @(negedge clk);
            checks++;
            if (d_gnt !== (c == 4) || p_stall !== (c == 4)) begin
                errors++;
                $display("FAIL starve_c%0d d_gnt=%b p_stall=%b exp %b", c, d_gnt, p_stall, c == 4);
            end
            tick();
            if (c == 4) set_d(0, 0, 64'h0, 64'h0);
        end
        idle();
        tick();
    endtask

    task automatic test_idle_d();
        set_d(1, 1, 64'h100, 64'h1234_5678_9ABC_DEF0);
        @(negedge clk);
        checks++;
        if (d_gnt !== 1'b1) begin errors++; $display("FAIL idle_d_wr_gnt got %b exp 1", d_gnt); end
        tick();
        set_d(1, 0, 64'h100, 64'h0);
        @(negedge clk);
        checks++;
        if (d_gnt !== 1'b1) begin errors++; $display("FAIL idle_d_rd_gnt got %b exp 1", d_gnt); end
        tick();
        idle();
        @(negedge clk);
        checks++;
        if (d_rvalid !== 1'b1 || mem_rdata !== 64'h1234_5678_9ABC_DEF0) begin
            errors++; $display("FAIL idle_d_read rv=%b data=%h exp rv=1 data=123456789abcdef0", d_rvalid, mem_rdata);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        set_p(1, K_LDL, 64'h40, 64'h0);
        tick();
        set_p(1, K_STC, 64'h40, 64'hDD);
        set_d(1, 1, 64'h40, 64'hEE);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({d_gnt, p_stall, mem_we, p_rvalid, d_rvalid, p_stc_ok} !== 6'b0) begin
            errors++;
            $display("FAIL midrst_outputs got %b exp 000000", {d_gnt, p_stall, mem_we, p_rvalid, d_rvalid, p_stc_ok});
        end
        tick();
        set_d(0, 0, 64'h0, 64'h0);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (mem_we !== 1'b0) begin errors++; $display("FAIL midrst_stc_we got %b exp 0", mem_we); end
        tick();
        idle();
        @(negedge clk);
        checks++;
        if (p_stc_ok !== 1'b0) begin errors++; $display("FAIL midrst_stc_ok got %b exp 0", p_stc_ok); end
        tick();
    endtask

    function automatic logic [63:0] rand_addr();
        logic [63:0] hi, lo;
        hi = {$urandom, $urandom} & ~64'(MASK);
        if ($urandom_range(0, 7) == 0) lo = $urandom_range(0, 1) ? 64'h3FC : 64'h002;
        else                           lo = 64'h40 + 64'(4 * $urandom_range(0, 6));
        return hi | lo;
    endfunction

    task automatic test_random();
        bit p_keep = 0, d_keep = 0;
        for (int n = 0; n < 400; n++) begin
            if (!p_keep) set_p($urandom_range(0, 9) < 7, $urandom_range(0, 3), rand_addr(), {$urandom, $urandom});
            if (!d_keep) set_d($urandom_range(0, 9) < 4, $urandom_range(0, 1), rand_addr(), {$urandom, $urandom});
            @(negedge clk);
            #1;
            p_keep = p_req && e_p_stall;
            d_keep = d_req && !e_d_gnt;
            tick();
        end
        idle();
        tick();
        tick();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst_n = 1'b0;
        idle();
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_resv_hit();
        test_resv_break();
        test_nonoverlap();
        test_starve();
        test_idle_d();
        test_reset_mid();
        test_random();
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL pending_reads got %0d exp 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Arbiter and sequencer for the single-ported data cache in the memory stage. It shares the cache between the pipeline memory port (P) and a secondary loader/debug port (D), and drives the cache address, write-data and write-enable. It owns the load-locked/store-conditional reservation (address plus valid bit) and decides store-conditional success. It sits between the memory-stage control and the cache, replacing direct pipeline drive of the cache write enable.

## Interface
Parameters:
- ADDR_BITS, 10, number of low address bits used by the cache (byte address).
- STARVE_MAX, 4, number of consecutive lost cycles after which D is forced a slot (1..15).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- p_req  in  1  pipeline access request this cycle.
- p_we  in  1  pipeline plain store.
- p_ldl  in  1  pipeline load-locked.
- p_stc  in  1  pipeline store-conditional.
- p_addr  in  64  pipeline byte address.
- p_wdata  in  64  pipeline store data.
- p_stall  out  1  pipeline not served this cycle; hold the request.
- p_rvalid  out  1  pipeline read data valid on mem_rdata this cycle.
- p_stc_ok  out  1  result of the previous cycle's granted stc.
- d_req  in  1  D request; held until granted.
- d_we  in  1  D write.
- d_addr  in  64  D byte address.
- d_wdata  in  64  D write data.
- d_gnt  out  1  D served this cycle.
- d_rvalid  out  1  D read data valid on mem_rdata this cycle.
- mem_addr  out  64  cache address.
- mem_wdata  out  64  cache write data.
- mem_we  out  1  cache write enable.
- mem_rdata  in  64  cache registered read data.

## Operation
- One access per cycle. The grant is combinational from the request inputs and registered state.
- Grant rule:
  - D is granted when p_req=0 and d_req=1.
  - D is also granted when d_req=1 and starve_cnt==STARVE_MAX (forced slot).
  - Otherwise P is granted if p_req=1.
- p_stall = p_req & d_gnt.
- starve_cnt (4 bits) updates each cycle:
  - increments when d_req=1 and D is not granted;
  - clears on a D grant or when d_req=0;
  - saturates at STARVE_MAX.
- Winner muxing: mem_addr and mem_wdata come from the winner. When neither port is granted they come from P.
- mem_we is set as follows:
  - P winner: mem_we = p_we | (p_stc & stc_hit).
  - D winner: mem_we = d_we.
  - No winner: mem_we = 0.
- Exactly one of p_we, p_ldl or p_stc is set per request; none set means a plain load.
- Overlap: two addresses overlap when (a-b) mod 2^ADDR_BITS < 8 or (b-a) mod 2^ADDR_BITS < 8, computed on the low ADDR_BITS bits.
- Reservation registers: resv_valid and resv_addr[ADDR_BITS-1:0].
  - P ldl granted: resv_valid<=1 and resv_addr<=p_addr.
  - P stc granted: stc_hit = resv_valid & (p_addr low bits == resv_addr). resv_valid<=0 whether or not it hits.
  - Any granted plain write (P or D) that overlaps resv_addr: resv_valid<=0.
  - A P ldl issued while a reservation is held replaces it.
- Read return: reads are registered, so the read issued in cycle N is valid on mem_rdata in N+1.
  - p_rvalid is raised in N+1 for a P ldl or plain load granted in N.
  - d_rvalid is raised in N+1 for a D read granted in N.
- p_stc_ok is registered and valid in N+1 for an stc granted in N. It holds its value until the next stc.

## Timing
- Reset (rst_n=0, asynchronous):
  - registered state cleared: resv_valid=0, resv_addr=0, starve_cnt=0, p_rvalid=0, d_rvalid=0, p_stc_ok=0;
  - combinational outputs are forced to 0 regardless of inputs: d_gnt=0, p_stall=0, mem_we=0.
- Reset mid-access: any pending return is dropped and the reservation is lost. The first cycle after release behaves as from idle.
- Latency: the grant is in the same cycle as the request. Read data and stc result arrive one cycle later.
- Handshakes:
  - D must hold d_req, d_addr, d_we and d_wdata stable until d_gnt.
  - P holds its request while p_stall=1.
- Back-to-back: a grant is possible every cycle. A P stc immediately after a P ldl to the same address with no intervening overlapping write succeeds.
- Worst-case D wait while p_req stays high: STARVE_MAX cycles, granted on cycle STARVE_MAX+1.

## Test plan
- Reservation set and hit: P ldl 0x40, then P stc 0x40 with wdata 0xAA.
  - Expect mem_we=1 in the stc cycle and p_stc_ok=1 the next cycle.
  - A read of 0x40 then returns 0xAA.
- Reservation broken by D: P ldl 0x40, then D write 0x44 (overlaps), then P stc 0x40.
  - Expect mem_we=0 in the stc cycle, p_stc_ok=0, and memory unchanged.
- Starvation: p_req held high continuously and d_req raised in cycle 0, with STARVE_MAX=4.
  - Expect d_gnt=1 and p_stall=1 in cycle 4 only; P is granted in cycles 0-3 and 5.
- Idle D access: p_req=0 and D read 0x100.
  - Expect d_gnt=1 in the same cycle and d_rvalid=1 the next cycle with the stored word.
- Reset mid-operation: assert rst_n=0 between an ldl and its stc.
  - Expect all outputs at 0 immediately; after release the stc fails (p_stc_ok=0).
- Non-overlap: P ldl 0x40, then D write 0x48 (no overlap), then P stc 0x40.
  - Expect the stc to succeed, p_stc_ok=1.
